// File: rtl/bcd_pkg.sv
// Shared definitions for the cascaded BCD timer: FSM state encoding and BCD digit limits.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Digits above 9 are not valid BCD; saturate them instead of wrapping.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_ud_digit.sv
// One BCD up/down digit: parallel load, single-step with 9<->0 wrap, and terminal-count flag.
module bcd_ud_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       tc
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      if (up) begin
        q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = up ? (q_q == BCD_MAX) : (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Cascaded BCD up/down timer with load/start/stop control and a one-cycle done pulse.
// Define BCD_TIMER_AUTORELOAD_EN to reload and keep running on terminal instead of stopping.
module bcd_timer_ctrl
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] preset,
  input  logic                    dir,
  input  logic                    start,
  input  logic                    stop,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    running,
  output logic                    done
);

`ifdef BCD_TIMER_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  state_e state_q, state_d;
  logic   dir_q, dir_d;
  logic   running_q, running_d;
  logic   done_q, done_d;
  logic [4*NUM_DIGITS-1:0] reload_q, reload_d;

  logic [4*NUM_DIGITS-1:0] count_w;
  logic [4*NUM_DIGITS-1:0] preset_clamped;
  logic [4*NUM_DIGITS-1:0] ld_value;
  logic [NUM_DIGITS-1:0]   tc;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic step_en;
  logic digit_ld;
  logic lower_tc;
  logic all_nine, all_zero, upper_nine, upper_zero;
  logic at_term, near_term;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      preset_clamped[4*i +: 4] = bcd_clamp(preset[4*i +: 4]);
    end
  end

  // near_term means the next step lands on the terminal value, so done can be registered on that edge.
  always_comb begin
    upper_nine = 1'b1;
    upper_zero = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (count_w[4*i +: 4] != BCD_MAX) upper_nine = 1'b0;
      if (count_w[4*i +: 4] != BCD_MIN) upper_zero = 1'b0;
    end
    all_nine  = upper_nine && (count_w[3:0] == BCD_MAX);
    all_zero  = upper_zero && (count_w[3:0] == BCD_MIN);
    at_term   = dir_q ? all_nine : all_zero;
    near_term = dir_q ? (upper_nine && (count_w[3:0] == (BCD_MAX - 4'd1)))
                      : (upper_zero && (count_w[3:0] == (BCD_MIN + 4'd1)));
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    step_en  = 1'b0;
    digit_ld = 1'b0;
    ld_value = reload_q;
    if (load) begin
      state_d  = ST_IDLE;
      reload_d = preset_clamped;
      digit_ld = 1'b1;
      ld_value = preset_clamped;
    end else if (stop && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (start && (state_q != ST_RUN)) begin
      dir_d = dir;
      if (dir ? all_nine : all_zero) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      if (at_term) begin
        if (AUTORELOAD) digit_ld = 1'b1;
        else            state_d  = ST_DONE;
      end else begin
        step_en = 1'b1;
        if (near_term) begin
          done_d = 1'b1;
          if (!AUTORELOAD) state_d = ST_DONE;
        end
      end
    end
    running_d = (state_d == ST_RUN);
  end

  // A digit steps only when every lower digit sits at its terminal value for the current direction.
  always_comb begin
    lower_tc = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_en[i] = step_en && lower_tc;
      lower_tc  = lower_tc && tc[i];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_ud_digit u_digit (
      .clk (clk),
      .rst (rst),
      .en  (dig_en[g]),
      .up  (dir_q),
      .ld  (digit_ld),
      .d   (ld_value[4*g +: 4]),
      .q   (count_w[4*g +: 4]),
      .tc  (tc[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      reload_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign count   = count_w;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl (NUM_DIGITS=2): directed scenarios plus randomized
// control traffic compared against an integer-valued timer model. Honors BCD_TIMER_AUTORELOAD_EN.
module tb_bcd_timer_ctrl;

  localparam int ND      = 2;
  localparam int TOP     = 99;
  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAUSE = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          load, start, stop, dir;
  logic [4*ND-1:0] preset;
  logic [4*ND-1:0] count;
  logic          running, done;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_count, m_reload, m_phase;
  bit m_dir, m_done;

  bcd_timer_ctrl #(.NUM_DIGITS(ND)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .preset  (preset),
    .dir     (dir),
    .start   (start),
    .stop    (stop),
    .count   (count),
    .running (running),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic int bcd_to_int_clamped(input logic [7:0] b);
    int hi, lo;
    hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int term_of(input bit up);
    return up ? TOP : 0;
  endfunction

  task automatic model_reset();
    m_count  = 0;
    m_reload = 0;
    m_phase  = P_IDLE;
    m_dir    = 1'b0;
    m_done   = 1'b0;
  endtask

  // Timer behaviour for one rising edge, expressed on the decimal value of the count.
  task automatic model_edge();
    bit autoreload;
`ifdef BCD_TIMER_AUTORELOAD_EN
    autoreload = 1'b1;
`else
    autoreload = 1'b0;
`endif
    m_done = 1'b0;
    if (load) begin
      m_count  = bcd_to_int_clamped(preset);
      m_reload = m_count;
      m_phase  = P_IDLE;
    end else if (stop && m_phase == P_RUN) begin
      m_phase = P_PAUSE;
    end else if (start && m_phase != P_RUN) begin
      m_dir = dir;
      if (m_count == term_of(dir)) begin
        m_phase = P_DONE;
        m_done  = 1'b1;
      end else begin
        m_phase = P_RUN;
      end
    end else if (m_phase == P_RUN) begin
      if (m_count == term_of(m_dir)) begin
        if (autoreload) m_count = m_reload;
        else            m_phase = P_DONE;
      end else begin
        m_count = m_dir ? m_count + 1 : m_count - 1;
        if (m_count == term_of(m_dir)) begin
          m_done = 1'b1;
          if (!autoreload) m_phase = P_DONE;
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic load_and_start(input logic [7:0] p, input logic d);
    load = 1'b1; preset = p;
    cycle();
    load = 1'b0; dir = d; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    dir = 1'b0;
    preset = '0;
    model_reset();
    #12;
    tests_run++;
    if (count !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL reset_count: got %h expected 00", count);
    end
    tests_run++;
    if (running !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_running: got %b expected 0", running);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_countdown();
    logic [7:0] seq [5];
    seq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    load_and_start(8'h05, 1'b0);
    tests_run++;
    if ({count, running, done} !== {8'h05, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL countdown_start: got %h/%b/%b expected 05/1/0", count, running, done);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests_run++;
      if ({count, running, done} !== {seq[i], (i != 4), (i == 4)}) begin
        tests_failed++;
        $display("[TB] FAIL countdown_step%0d: got %h/%b/%b expected %h/%b/%b",
                 i, count, running, done, seq[i], (i != 4), (i == 4));
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests_run++;
      if ({count, running, done} !== {8'h00, 1'b0, 1'b0}) begin
        tests_failed++; $display("[TB] FAIL countdown_hold%0d: got %h/%b/%b expected 00/0/0", i, count, running, done);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [7:0] seq [5];
    seq = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00};
    load_and_start(8'h02, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests_run++;
      if ({count, running, done} !== {seq[i], 1'b1, (seq[i] == 8'h00)}) begin
        tests_failed++;
        $display("[TB] FAIL autoreload_step%0d: got %h/%b/%b expected %h/1/%b",
                 i, count, running, done, seq[i], (seq[i] == 8'h00));
      end
    end
  endtask

  task automatic test_cascade_stop();
    logic [7:0] seq [3];
    seq = '{8'h20, 8'h21, 8'h22};
    load_and_start(8'h19, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if ({count, running} !== {seq[i], 1'b1}) begin
        tests_failed++; $display("[TB] FAIL cascade_step%0d: got %h/%b expected %h/1", i, count, running, seq[i]);
      end
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({count, running, done} !== {8'h22, 1'b0, 1'b0}) begin
        tests_failed++; $display("[TB] FAIL pause_hold%0d: got %h/%b/%b expected 22/0/0", i, count, running, done);
      end
      cycle();
    end
  endtask

  task automatic test_load_priority();
    load_and_start(8'h37, 1'b1);
    cycle();
    cycle();
    load = 1'b1; stop = 1'b1; start = 1'b1; preset = 8'h42;
    cycle();
    idle_inputs();
    tests_run++;
    if ({count, running, done} !== {8'h42, 1'b0, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL load_priority: got %h/%b/%b expected 42/0/0", count, running, done);
    end
    cycle();
    tests_run++;
    if ({count, running} !== {8'h42, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL idle_hold: got %h/%b expected 42/0", count, running);
    end
    load_and_start(8'hAF, 1'b1);
    tests_run++;
    if ({count, running, done} !== {8'h99, 1'b0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL clamp_terminal_up: got %h/%b/%b expected 99/0/1", count, running, done);
    end
  endtask

  task automatic test_zero_start();
    load_and_start(8'h00, 1'b0);
    tests_run++;
    if ({count, running, done} !== {8'h00, 1'b0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL zero_start: got %h/%b/%b expected 00/0/1", count, running, done);
    end
    cycle();
    tests_run++;
    if ({count, running, done} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL zero_after: got %h/%b/%b expected 00/0/0", count, running, done);
    end
  endtask

  task automatic test_async_reset();
    load_and_start(8'h50, 1'b0);
    cycle();
    cycle();
    cycle();
    tests_run++;
    if ({count, running} !== {8'h47, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL pre_reset_run: got %h/%b expected 47/1", count, running);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if ({count, running, done} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL async_reset: got %h/%b/%b expected 00/0/0", count, running, done);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({count, running, done} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL reset_held: got %h/%b/%b expected 00/0/0", count, running, done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int r;
    load = 1'b1; preset = 8'h03;
    cycle();
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      r     = int'($urandom_range(0, 99));
      load  = (r < 3);
      stop  = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 5) == 0);
      dir   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       preset = 8'($urandom);
        1:       preset = 8'h02;
        2:       preset = 8'h96;
        default: preset = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      if (stop && start && !load && m_phase != P_RUN) stop = 1'b0;
      cycle();
      tests_run++;
      if ({count, running, done} !== {int_to_bcd(m_count), (m_phase == P_RUN), m_done}) begin
        tests_failed++;
        $display("[TB] FAIL random_cycle%0d: got %h/%b/%b expected %h/%b/%b",
                 n, count, running, done, int_to_bcd(m_count), (m_phase == P_RUN), m_done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
`ifdef BCD_TIMER_AUTORELOAD_EN
    test_autoreload();
`else
    test_countdown();
`endif
    test_cascade_stop();
    test_load_priority();
    test_zero_start();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, meaning the number of cascaded BCD digits (1..4).
REQ-002 SHALL have port clk, input, 1, meaning the system clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, meaning the reset: asynchronous, active-low.
REQ-004 SHALL have port load, input, 1, meaning copy preset into count and latch it as the reload value.
REQ-005 SHALL have port preset, input, 4*NUM_DIGITS, meaning the BCD start value; digit 0 is in bits [3:0].
REQ-006 SHALL have port dir, input, 1, meaning count direction: 1 = up, 0 = down; sampled only on an accepted start.
REQ-007 SHALL have port start, input, 1, meaning begin or resume counting.
REQ-008 SHALL have port stop, input, 1, meaning pause counting.
REQ-009 SHALL have port count, output, 4*NUM_DIGITS, meaning the current BCD value.
REQ-010 SHALL have port running, output, 1, meaning high while the FSM is in RUN.
REQ-011 SHALL have port done, output, 1, meaning a one-cycle pulse when the terminal value is reached.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN, PAUSE and DONE.
REQ-013 SHALL give control inputs the priority load > stop > start when several are asserted in the same cycle.
REQ-014 SHALL, on load in any state: set count to preset, store preset as the reload value, go to IDLE, and not count in that cycle.
REQ-015 SHALL clamp any preset digit above 9 to 9 on load.
REQ-016 SHALL, on start in IDLE, PAUSE or DONE: latch dir and go to RUN at that edge; the first count step occurs on the next edge.
REQ-017 SHALL, in RUN, step count by exactly one BCD unit per clock.
REQ-018 SHALL step the digits synchronously: digit i steps only when every lower digit is 9 (up) or 0 (down), with 9->0 wrap on up and 0->9 wrap on down.
REQ-019 SHALL define the terminal value as all digits 9 when counting up and all digits 0 when counting down.
REQ-020 SHALL, on the edge where count becomes terminal: assert done for the following cycle only and go to DONE, then hold count.
REQ-021 SHALL, on start when count already equals the terminal value for the sampled dir: go directly to DONE, pulse done for one cycle, and leave count unchanged.
REQ-022 SHALL, on stop in RUN: go to PAUSE and freeze count; stop in any other state SHALL have no effect.
REQ-023 SHALL ignore start while already in RUN, and SHALL ignore dir changes while in RUN.
REQ-024 SHALL register running and done, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, while rst is low: set count to 0, reload value to 0, state to IDLE, running to 0, done to 0 and latched dir to 0, independent of clk.
REQ-026 SHALL abort counting immediately on reset mid-RUN, with no done pulse generated.

Configuration
REQ-027 SHALL, when macro BCD_TIMER_AUTORELOAD_EN is defined: on reaching terminal in RUN, pulse done, load count with the reload value on the next edge, and remain in RUN.
REQ-028 SHALL, without BCD_TIMER_AUTORELOAD_EN, behave exactly as REQ-020 (stop in DONE).

Structure
REQ-029 SHALL take the FSM state encoding and the BCD digit constants (BCD_MAX=9, BCD_MIN=0) from shared package bcd_pkg.
REQ-030 SHALL instantiate one sub-module bcd_ud_digit per digit; each has inputs en, up, ld, d[3:0] and outputs q[3:0], tc (9 when up, 0 when down).
REQ-031 SHALL keep cascade enables and the FSM in bcd_timer_ctrl; bcd_ud_digit SHALL contain no control logic.

Verification
REQ-032 SHALL cover: NUM_DIGITS=2, load preset 0x05, dir=0, start -> count 04,03,02,01,00 on successive edges, done high exactly one cycle, state DONE, count holds 00.
REQ-033 SHALL cover: load 0x19, dir=1, start -> count 0x20 after the first step (digit cascade); stop after 3 steps -> count holds 0x22 and running=0.
REQ-034 SHALL cover: load, stop and start asserted together in RUN -> count = preset, state IDLE, running=0.
REQ-035 SHALL cover: load 0x00, dir=0, start -> no count step, done pulses one cycle, state DONE.
REQ-036 SHALL cover: rst driven low mid-RUN between clock edges -> count 0x00, running=0, done=0 immediately.
REQ-037 SHALL cover, with BCD_TIMER_AUTORELOAD_EN: load 0x02, dir=0, start -> sequence 01,00,02,01,00, done pulsing at each 00, running stays 1.
